// File: rtl/twi_byte_engine.sv
// twi_byte_engine -- byte-level two-wire (I2C-style) bus master.
//
// One command at a time: START, WRITE (8 bits + slave ACK), READ (8 bits +
// master ACK/NACK) or STOP. Every bus bit is split into four equal phases.
// Each phase lasts CLK_DIV clock cycles. The slave may stretch the clock
// while SCL is released.
//
// Handshake: a command is taken on a rising edge where iCmdValid and
// oCmdReady are both 1. oCmdReady is low from the next cycle until the cycle
// after the one-cycle oDone pulse. iCmdValid while oCmdReady is low is ignored.
//
// Ports:
//   iClk, iResetN        clock and asynchronous active-low reset
//   iCmdValid, iCmd      command request / code (1 START, 2 WRITE, 3 READ,
//                        4 STOP, others NOP)
//   iTxData, iRxNack     WRITE byte and READ ack-bit value, taken on accept
//   oCmdReady, oDone     idle indication, completion pulse
//   oRxData, oAckErr     last READ byte, NACK seen on last WRITE
//   oBusOwned            START issued and no STOP completed since
//   iSda, iScl           raw bus levels (synchronized internally)
//   oSda, oScl           open-drain controls (0 pulls low, 1 releases)
//   oState               current FSM state, for debug and checkers
module twi_byte_engine #(
    parameter int CLK_DIV = 250
) (
    input  logic       iClk,
    input  logic       iResetN,
    input  logic       iCmdValid,
    input  logic [2:0] iCmd,
    input  logic [7:0] iTxData,
    input  logic       iRxNack,
    output logic       oCmdReady,
    output logic       oDone,
    output logic [7:0] oRxData,
    output logic       oAckErr,
    output logic       oBusOwned,
    input  logic       iSda,
    input  logic       iScl,
    output logic       oSda,
    output logic       oScl,
    output logic [2:0] oState
);

    localparam int            CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WRBIT = 3'd2,
        WRACK = 3'd3,
        RDBIT = 3'd4,
        RDACK = 3'd5,
        STOP  = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_phase;
    logic [3:0]    r_bit;
    logic [2:0]    r_cmd;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_ack;
    logic          r_nack;
    logic          r_done;
    logic          r_bus_owned;
    logic [7:0]    r_rx_data;
    logic          r_ack_err;
    logic [1:0]    r_sda_sync;
    logic [1:0]    r_scl_sync;
    logic [1:0]    r_scl_echo;
    logic          r_sda_hold;
    logic          r_scl_hold;

    logic w_sda_s;
    logic w_scl_s;
    logic w_accept;
    logic w_active;
    logic w_scl_hi;
    logic w_stretch;
    logic w_tick;
    logic w_phase_end;
    logic w_sample;
    logic w_sda;
    logic w_scl;

    assign w_sda_s  = r_sda_sync[1];
    assign w_scl_s  = r_scl_sync[1];
    assign w_accept = iCmdValid && oCmdReady;
    assign w_active = (r_state != IDLE) && (r_state != DONE);
    assign w_scl_hi = (r_phase == 2'd1) || (r_phase == 2'd2);

    // r_scl_echo is our own SCL delayed by the synchronizer depth. A low
    // synchronized SCL only counts as stretching once our release has had
    // time to reach the synchronizer output; otherwise every rising edge
    // would look stretched for two cycles.
    assign w_stretch   = w_active && w_scl_hi && r_scl_echo[1] && !w_scl_s;
    assign w_tick      = w_active && (r_cnt == '0) && !w_stretch;
    assign w_phase_end = w_tick && (r_phase == 2'd3);
    assign w_sample    = w_tick && (r_phase == 2'd1);

    // Bus lines follow the current phase while a command runs; otherwise
    // they keep the last driven value (the final phase of the last command).
    always_comb begin
        w_state_nxt = r_state;
        w_sda       = r_sda_hold;
        w_scl       = r_scl_hold;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (iCmd)
                        CMD_START: w_state_nxt = START;
                        CMD_WRITE: w_state_nxt = WRBIT;
                        CMD_READ:  w_state_nxt = RDBIT;
                        CMD_STOP:  w_state_nxt = STOP;
                        default:   w_state_nxt = DONE;
                    endcase
                end
            end
            START: begin
                w_sda = (r_phase < 2'd2);
                w_scl = (r_phase != 2'd3);
                if (w_phase_end) w_state_nxt = DONE;
            end
            WRBIT: begin
                w_sda = r_tx[7];
                w_scl = w_scl_hi;
                if (w_phase_end && (r_bit == 4'd7)) w_state_nxt = WRACK;
            end
            WRACK: begin
                w_sda = 1'b1;
                w_scl = w_scl_hi;
                if (w_phase_end) w_state_nxt = DONE;
            end
            RDBIT: begin
                w_sda = 1'b1;
                w_scl = w_scl_hi;
                if (w_phase_end && (r_bit == 4'd7)) w_state_nxt = RDACK;
            end
            RDACK: begin
                w_sda = r_nack;
                w_scl = w_scl_hi;
                if (w_phase_end) w_state_nxt = DONE;
            end
            STOP: begin
                w_sda = (r_phase == 2'd3);
                w_scl = (r_phase != 2'd0);
                if (w_phase_end) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            r_cnt       <= '0;
            r_phase     <= 2'd0;
            r_bit       <= 4'd0;
            r_cmd       <= 3'd0;
            r_tx        <= 8'h00;
            r_rx        <= 8'h00;
            r_ack       <= 1'b0;
            r_nack      <= 1'b0;
            r_done      <= 1'b0;
            r_bus_owned <= 1'b0;
            r_rx_data   <= 8'h00;
            r_ack_err   <= 1'b0;
            r_sda_sync  <= 2'b11;
            r_scl_sync  <= 2'b11;
            r_scl_echo  <= 2'b11;
            r_sda_hold  <= 1'b1;
            r_scl_hold  <= 1'b1;
        end else begin
            r_sda_sync <= {r_sda_sync[0], iSda};
            r_scl_sync <= {r_scl_sync[0], iScl};
            r_scl_echo <= {r_scl_echo[0], w_scl};
            r_sda_hold <= w_sda;
            r_scl_hold <= w_scl;
            r_done     <= (r_state == DONE);

            if (w_accept) begin
                r_cnt   <= RELOAD;
                r_phase <= 2'd0;
                r_bit   <= 4'd0;
                r_cmd   <= iCmd;
                r_tx    <= iTxData;
                r_nack  <= iRxNack;
            end else if (w_active && !w_stretch) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_cnt   <= RELOAD;
                    r_phase <= r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        r_bit <= r_bit + 4'd1;
                        if (r_state == WRBIT) r_tx <= {r_tx[6:0], 1'b0};
                    end
                end
            end

            if (w_sample) begin
                if (r_state == RDBIT) r_rx  <= {r_rx[6:0], w_sda_s};
                if (r_state == WRACK) r_ack <= w_sda_s;
            end

            // Visible results change together with the oDone pulse.
            if (r_state == DONE) begin
                case (r_cmd)
                    CMD_START: r_bus_owned <= 1'b1;
                    CMD_STOP:  r_bus_owned <= 1'b0;
                    CMD_WRITE: r_ack_err   <= r_ack;
                    CMD_READ:  r_rx_data   <= r_rx;
                    default:   ;
                endcase
            end
        end
    end

    assign oCmdReady = (r_state == IDLE) && !r_done;
    assign oDone     = r_done;
    assign oRxData   = r_rx_data;
    assign oAckErr   = r_ack_err;
    assign oBusOwned = r_bus_owned;
    assign oSda      = w_sda;
    assign oScl      = w_scl;
    assign oState    = r_state;

endmodule

// File: tb/tb_twi_byte_engine.sv
// Testbench for twi_byte_engine with CLK_DIV=4.
// A small slave model drives SDA bit slots from a per-command program and can
// stretch SCL. It records the bus SDA level at each SCL rising edge, and it
// counts START and STOP conditions.
module tb_twi_byte_engine;

    localparam int CLK_DIV = 4;
    localparam int LIMIT   = 400;

    logic       iClk = 1'b0;
    logic       iResetN = 1'b0;
    logic       iCmdValid = 1'b0;
    logic [2:0] iCmd = 3'd0;
    logic [7:0] iTxData = 8'h00;
    logic       iRxNack = 1'b0;
    logic       oCmdReady, oDone, oAckErr, oBusOwned, oSda, oScl;
    logic [7:0] oRxData;
    logic [2:0] oState;

    logic       slv_sda = 1'b1;
    logic       slv_hold = 1'b0;
    logic [9:0] slv_prog = 10'h3FF;
    logic       w_bus_sda, w_bus_scl;

    assign w_bus_sda = oSda & slv_sda;
    assign w_bus_scl = oScl & ~slv_hold;

    twi_byte_engine #(.CLK_DIV(CLK_DIV)) dut (
        .iClk(iClk), .iResetN(iResetN), .iCmdValid(iCmdValid), .iCmd(iCmd),
        .iTxData(iTxData), .iRxNack(iRxNack), .oCmdReady(oCmdReady),
        .oDone(oDone), .oRxData(oRxData), .oAckErr(oAckErr),
        .oBusOwned(oBusOwned), .iSda(w_bus_sda), .iScl(w_bus_scl),
        .oSda(oSda), .oScl(oScl), .oState(oState)
    );

    // clock
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_errors = 0;

    // slave / bus monitor
    int   rise_cnt = 0, rise_base = 0;
    int   start_cnt = 0, stop_cnt = 0;
    int   stretch_at = 0;
    int   hold_rem = 0;
    logic mon_prev_scl = 1'b1, mon_prev_sda = 1'b1;
    logic [0:0] act_q[$];
    logic [0:0] exp_q[$];

    always @(negedge iClk) begin
        int ridx;
        if (oScl && !mon_prev_scl) begin
            rise_cnt++;
            act_q.push_back(w_bus_sda);
            if (stretch_at != 0 && (rise_cnt - rise_base) == stretch_at) hold_rem = 10;
        end
        if (!oSda && mon_prev_sda && oScl && mon_prev_scl) start_cnt++;
        if (oSda && !mon_prev_sda && oScl && mon_prev_scl) stop_cnt++;
        mon_prev_scl = oScl;
        mon_prev_sda = oSda;
        ridx = rise_cnt - rise_base;
        if (!oScl) slv_sda = (ridx >= 0 && ridx < 10) ? slv_prog[ridx] : 1'b1;
        if (hold_rem > 0) begin
            slv_hold = 1'b1;
            hold_rem--;
        end else begin
            slv_hold = 1'b0;
        end
    end

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] tx;
        logic       nack;
        logic [9:0] prog;
        int         st;
        int         lmin, lmax;
        int         nrise;
        logic [8:0] bits;
        int         nstart, nstop;
        logic [7:0] rx;
        logic       ack, owned, sda_e, scl_e, noise;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [2:0] cmd, input logic [7:0] tx, input logic nack,
                                input logic [9:0] prog, input int st, input int lmin, input int lmax,
                                input int nrise, input logic [8:0] bits, input int nstart, input int nstop,
                                input logic [7:0] rx, input logic ack, input logic owned,
                                input logic sda_e, input logic scl_e, input logic noise);
        vec_t v;
        v.cmd = cmd; v.tx = tx; v.nack = nack; v.prog = prog; v.st = st;
        v.lmin = lmin; v.lmax = lmax; v.nrise = nrise; v.bits = bits;
        v.nstart = nstart; v.nstop = nstop; v.rx = rx; v.ack = ack; v.owned = owned;
        v.sda_e = sda_e; v.scl_e = scl_e; v.noise = noise;
        return v;
    endfunction

    // slave program for a READ: byte MSB first, then release
    function automatic logic [9:0] rd_prog(input logic [7:0] d);
        logic [9:0] p;
        p = 10'h3FF;
        for (int i = 0; i < 8; i++) p[i] = d[7-i];
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [7:0] tx, input logic nack,
                         input logic [9:0] prog, input int st);
        @(negedge iClk);
        #2;
        slv_prog   = prog;
        stretch_at = st;
        rise_base  = rise_cnt;
        act_q.delete();
        iCmdValid  = 1'b1;
        iCmd       = cmd;
        iTxData    = tx;
        iRxNack    = nack;
        @(posedge iClk);
        @(negedge iClk);
        iCmdValid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int lat, s0, p0;
        s0 = start_cnt;
        p0 = stop_cnt;
        exp_q.delete();
        for (int i = 0; i < v.nrise; i++) exp_q.push_back(v.bits[8-i]);
        issue(v.cmd, v.tx, v.nack, v.prog, v.st);
        check($sformatf("row%0d_ready_drop", id), oCmdReady, 0);
        lat = 0;
        while (!oDone && lat < LIMIT) begin
            @(negedge iClk);
            lat++;
            iCmdValid = v.noise && lat >= 5 && lat <= 8;
            iCmd      = v.noise ? 3'd4 : v.cmd;
        end
        iCmdValid = 1'b0;
        n_checks++;
        if (lat < v.lmin || lat > v.lmax) begin
            n_errors++;
            $display("FAIL row%0d_latency: actual=%0d required=%0d..%0d", id, lat, v.lmin, v.lmax);
        end
        check($sformatf("row%0d_rxdata", id), oRxData, v.rx);
        check($sformatf("row%0d_ackerr", id), oAckErr, v.ack);
        check($sformatf("row%0d_owned", id), oBusOwned, v.owned);
        @(negedge iClk);
        check($sformatf("row%0d_ready_after", id), oCmdReady, 1);
        check($sformatf("row%0d_sda_end", id), oSda, v.sda_e);
        check($sformatf("row%0d_scl_end", id), oScl, v.scl_e);
        check($sformatf("row%0d_starts", id), start_cnt - s0, v.nstart);
        check($sformatf("row%0d_stops", id), stop_cnt - p0, v.nstop);
        check($sformatf("row%0d_nrise", id), act_q.size(), v.nrise);
        for (int i = 0; exp_q.size() > 0 && act_q.size() > 0; i++) begin
            logic [0:0] e, a;
            e = exp_q.pop_front();
            a = act_q.pop_front();
            check($sformatf("row%0d_bit%0d", id, i), a, e);
        end
    endtask

    initial begin
        int dn;
        //           cmd tx     nk prog          st lmin lmax nr bits          ns np rx     ak ow sd sc nz
        vecs[0]  = mk(1, 8'h00, 0, 10'h3FF,     0, 17,  17,  0, 9'h000,       1, 0, 8'h00, 0, 1, 0, 0, 0);
        vecs[1]  = mk(2, 8'hA5, 0, 10'h2FF,     0, 145, 145, 9, {8'hA5,1'b0}, 0, 0, 8'h00, 0, 1, 1, 0, 1);
        vecs[2]  = mk(2, 8'h3C, 0, 10'h3FF,     0, 145, 145, 9, {8'h3C,1'b1}, 0, 0, 8'h00, 1, 1, 1, 0, 0);
        vecs[3]  = mk(3, 8'h00, 1, rd_prog(8'h3C), 0, 145, 145, 9, {8'h3C,1'b1}, 0, 0, 8'h3C, 1, 1, 1, 0, 0);
        vecs[4]  = mk(3, 8'h00, 0, rd_prog(8'h96), 0, 145, 145, 9, {8'h96,1'b0}, 0, 0, 8'h96, 1, 1, 0, 0, 0);
        vecs[5]  = mk(0, 8'h00, 0, 10'h3FF,     0, 1,   1,   0, 9'h000,       0, 0, 8'h96, 1, 1, 0, 0, 0);
        vecs[6]  = mk(1, 8'h00, 0, 10'h3FF,     0, 17,  17,  1, 9'h100,       1, 0, 8'h96, 1, 1, 0, 0, 0);
        vecs[7]  = mk(4, 8'h00, 0, 10'h3FF,     0, 17,  17,  1, 9'h000,       0, 1, 8'h96, 1, 0, 1, 1, 0);
        vecs[8]  = mk(7, 8'h00, 0, 10'h3FF,     0, 1,   1,   0, 9'h000,       0, 0, 8'h96, 1, 0, 1, 1, 0);
        vecs[9]  = mk(2, 8'h5A, 0, 10'h2FF,     0, 145, 145, 9, {8'h5A,1'b0}, 0, 0, 8'h96, 0, 0, 1, 0, 0);
        vecs[10] = mk(4, 8'h00, 0, 10'h3FF,     0, 17,  17,  1, 9'h000,       0, 1, 8'h96, 0, 0, 1, 1, 0);
        vecs[11] = mk(1, 8'h00, 0, 10'h3FF,     0, 17,  17,  0, 9'h000,       1, 0, 8'h96, 0, 1, 0, 0, 0);
        vecs[12] = mk(2, 8'h81, 0, 10'h2FF,     4, 155, 157, 9, {8'h81,1'b0}, 0, 0, 8'h96, 0, 1, 1, 0, 0);
        // STOP right after a reset that aborted a READ
        vecs[13] = mk(4, 8'h00, 0, 10'h3FF,     0, 17,  17,  1, 9'h000,       0, 1, 8'h00, 0, 0, 1, 1, 0);

        // reset state
        repeat (3) @(negedge iClk);
        check("rst_sda", oSda, 1);
        check("rst_scl", oScl, 1);
        check("rst_ready", oCmdReady, 1);
        check("rst_done", oDone, 0);
        check("rst_rxdata", oRxData, 0);
        check("rst_ackerr", oAckErr, 0);
        check("rst_owned", oBusOwned, 0);
        check("rst_state", oState, 0);
        iResetN = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
            if (vecs[i].noise) begin
                // a request made while busy must not be queued
                dn = 0;
                repeat (20) begin
                    @(negedge iClk);
                    if (oDone) dn++;
                end
                check($sformatf("row%0d_no_queued_done", i), dn, 0);
                check($sformatf("row%0d_no_queued_owned", i), oBusOwned, 1);
            end
        end

        // reset in the middle of a READ
        issue(3'd3, 8'h00, 1'b0, rd_prog(8'hF0), 0);
        repeat (40) @(negedge iClk);
        iResetN = 1'b0;
        #1;
        check("midrst_sda", oSda, 1);
        check("midrst_scl", oScl, 1);
        check("midrst_ready", oCmdReady, 1);
        check("midrst_owned", oBusOwned, 0);
        check("midrst_state", oState, 0);
        dn = 0;
        repeat (3) begin
            @(negedge iClk);
            if (oDone) dn++;
        end
        check("midrst_no_done", dn, 0);
        iResetN = 1'b1;
        run_vec(vecs[13], 13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
